mem_port_arbiter: RTL and testbench

- Shares one single-ported, handshaked memory port between instruction fetch (read-only) and the MEM stage (load/store).
- Sits between if_stage/ex_me outputs and the RAM model. The hazard unit uses its busy/grant signals to stall the pipeline.
- Data requests have priority. A streak counter prevents fetch starvation, and a timeout counter recovers from a memory that never acknowledges.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one handshaked memory port between fetch and load/store
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [DATA_W-1:0] data_wmask,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_wmask,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  state_t            r_state;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_wmask;
  logic [TW-1:0]     r_timer;
  logic [SW-1:0]     r_streak;
  logic              r_err;
  logic [DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0] r_data_rdata;

  logic w_idle;
  logic w_starved;
  logic w_data_win;
  logic w_inst_win;
  logic w_timeout;

  // Grants are combinational from IDLE; gating with rst keeps every output low while reset is held.
  assign w_idle     = (r_state == ST_IDLE) && !rst;
  assign w_starved  = inst_req && (r_streak == SW'(MAX_STREAK));
  assign w_data_win = data_req && !w_starved;
  assign w_inst_win = inst_req && !w_data_win;
  assign w_timeout  = (r_timer == TW'(TIMEOUT - 1));

  assign data_gnt    = w_idle && w_data_win;
  assign inst_gnt    = w_idle && w_inst_win;
  assign busy        = (r_state != ST_IDLE);
  assign mem_req     = (r_state == ST_BUSY);
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign mem_wmask   = r_wmask;
  assign inst_rvalid = (r_state == ST_RESP) && !r_owner;
  assign data_rvalid = (r_state == ST_RESP) && r_owner;
  assign err         = (r_state == ST_RESP) && r_err;
  assign inst_rdata  = r_inst_rdata;
  assign data_rdata  = r_data_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_timer      <= '0;
      r_streak     <= '0;
      r_err        <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (data_gnt) begin
            r_owner <= 1'b1;
            r_we    <= data_we;
            r_addr  <= data_addr;
            r_wdata <= data_wdata;
            r_wmask <= data_wmask;
            r_timer <= '0;
            r_state <= ST_BUSY;
          end else if (inst_gnt) begin
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= inst_addr;
            r_wdata <= '0;
            r_wmask <= '0;
            r_timer <= '0;
            r_state <= ST_BUSY;
          end
          // Streak counts data wins that a waiting fetch lost.
          if (data_gnt && inst_req) begin
            if (r_streak != SW'(MAX_STREAK))
              r_streak <= r_streak + SW'(1);
          end else if (inst_gnt || !inst_req) begin
            r_streak <= '0;
          end
        end
        ST_BUSY: begin
          r_timer <= r_timer + TW'(1);
          if (mem_ack) begin
            r_err <= 1'b0;
            if (r_owner)
              r_data_rdata <= r_we ? '0 : mem_rdata;
            else
              r_inst_rdata <= mem_rdata;
            r_state <= ST_RESP;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (r_owner)
              r_data_rdata <= '0;
            else
              r_inst_rdata <= '0;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [63:0] inst_addr = '0;
  logic        inst_gnt, inst_rvalid;
  logic [63:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [63:0] data_addr = '0;
  logic [63:0] data_wdata = '0;
  logic [63:0] data_wmask = '0;
  logic        data_gnt, data_rvalid;
  logic [63:0] data_rdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_wmask;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata;
  logic        busy, err;

  int          checks = 0;
  int          errors = 0;
  int          ack_delay = -1;
  int          mcnt = 0;
  logic [63:0] mem_rdata_val = '0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wmask(data_wmask), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Memory model: acks in the (ack_delay+1)-th cycle of mem_req; ack_delay<0 never acks.
  assign mem_rdata = mem_ack ? mem_rdata_val : 64'h0;
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ack = (mcnt == ack_delay);
      mcnt = mcnt + 1;
    end else begin
      mem_ack = 1'b0;
      mcnt = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  task automatic wait_idle;
    for (int c = 0; c < 20; c++) begin
      samp;
      if (!busy) break;
      tick;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle busy=%0b required 0", busy); end
    tick;
  endtask

  task automatic test_reset;
    inst_req = 1'b1;
    data_req = 1'b1;
    samp;
    checks++;
    if ({inst_gnt, data_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b required 00", {inst_gnt, data_gnt}); end
    checks++;
    if ({busy, mem_req, mem_we, err, inst_rvalid, data_rvalid} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b required 000000", {busy, mem_req, mem_we, err, inst_rvalid, data_rvalid});
    end
    checks++;
    if ({mem_addr, inst_rdata, data_rdata} !== 192'h0) begin errors++; $display("FAIL reset_data got nonzero addr/rdata required 0"); end
    tick;
    inst_req = 1'b0;
    data_req = 1'b0;
    rst = 1'b0;
    samp;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %0b required 0", busy); end
    tick;
  endtask

  task automatic test_single_load;
    data_req = 1'b1; data_we = 1'b0; data_addr = 64'h8000_0010;
    ack_delay = 1; mem_rdata_val = 64'hDEAD_BEEF;
    samp;
    checks++;
    if ({data_gnt, inst_gnt} !== 2'b10) begin errors++; $display("FAIL load_gnt got %b required 10", {data_gnt, inst_gnt}); end
    tick;
    data_req = 1'b0;
    samp;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h8000_0010) begin
      errors++; $display("FAIL load_c1 req=%0b we=%0b addr=%h required 1 0 80000010", mem_req, mem_we, mem_addr);
    end
    tick;
    samp;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL load_c2 mem_req=%0b required 1", mem_req); end
    tick;
    samp;
    checks++;
    if (data_rvalid !== 1'b1 || data_rdata !== 64'hDEAD_BEEF || err !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL load_c3 rvalid=%0b rdata=%h err=%0b req=%0b required 1 deadbeef 0 0", data_rvalid, data_rdata, err, mem_req);
    end
    tick;
    samp;
    checks++;
    if (busy !== 1'b0 || data_rvalid !== 1'b0) begin errors++; $display("FAIL load_c4 busy=%0b rvalid=%0b required 0 0", busy, data_rvalid); end
    tick;
  endtask

  task automatic test_store;
    data_req = 1'b1; data_we = 1'b1; data_addr = 64'h8000_0020;
    data_wdata = 64'h11; data_wmask = 64'hFF; ack_delay = 1; mem_rdata_val = 64'h5555;
    samp;
    checks++;
    if (data_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt got %0b required 1", data_gnt); end
    tick;
    data_req = 1'b0; data_we = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      samp;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wmask !== 64'hFF || mem_wdata !== 64'h11 || mem_addr !== 64'h8000_0020) begin
        errors++; $display("FAIL store_c%0d req=%0b we=%0b mask=%h wdata=%h required 1 1 ff 11", c, mem_req, mem_we, mem_wmask, mem_wdata);
      end
      tick;
    end
    samp;
    checks++;
    if (data_rvalid !== 1'b1 || inst_rvalid !== 1'b0 || data_rdata !== 64'h0 || err !== 1'b0) begin
      errors++; $display("FAIL store_resp drv=%0b irv=%0b rdata=%h err=%0b required 1 0 0 0", data_rvalid, inst_rvalid, data_rdata, err);
    end
    tick;
    wait_idle;
  endtask

  task automatic test_conflict;
    logic [9:0] got;
    logic [9:0] exp_order;
    int n;
    int overlap;
    got = '0; n = 0; overlap = 0;
    exp_order = 10'b01111_01111;
    inst_req = 1'b1; inst_addr = 64'h8000_0040;
    data_req = 1'b1; data_we = 1'b0; data_addr = 64'h8000_0080;
    ack_delay = 0; mem_rdata_val = 64'hCAFE_F00D;
    for (int c = 0; c < 60 && n < 10; c++) begin
      samp;
      if (inst_gnt && data_gnt) overlap++;
      if (data_gnt) begin got[n] = 1'b1; n++; end
      else if (inst_gnt) begin got[n] = 1'b0; n++; end
      tick;
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL conflict_overlap got %0d cycles required 0", overlap); end
    checks++;
    if (n !== 10) begin errors++; $display("FAIL conflict_count got %0d grants required 10", n); end
    checks++;
    if (got !== exp_order) begin errors++; $display("FAIL conflict_order got %b required %b (bit0 first, 1=D)", got, exp_order); end
    wait_idle;
    checks++;
    if (inst_rdata !== 64'hCAFE_F00D || data_rdata !== 64'hCAFE_F00D) begin
      errors++; $display("FAIL conflict_rdata inst=%h data=%h required cafef00d", inst_rdata, data_rdata);
    end
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    inst_req = 1'b1; inst_addr = 64'h8000_0100; ack_delay = -1;
    samp;
    checks++;
    if (inst_gnt !== 1'b1) begin errors++; $display("FAIL timeout_gnt got %0b required 1", inst_gnt); end
    tick;
    inst_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      samp;
      if (!mem_req) break;
      n++;
      tick;
    end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL timeout_len got %0d mem_req cycles required 8", n); end
    checks++;
    if (inst_rvalid !== 1'b1 || err !== 1'b1 || inst_rdata !== 64'h0 || data_rvalid !== 1'b0) begin
      errors++; $display("FAIL timeout_resp irv=%0b err=%0b rdata=%h drv=%0b required 1 1 0 0", inst_rvalid, err, inst_rdata, data_rvalid);
    end
    tick;
    samp;
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || inst_rvalid !== 1'b0) begin
      errors++; $display("FAIL timeout_after busy=%0b err=%0b irv=%0b required 0 0 0", busy, err, inst_rvalid);
    end
    tick;
  endtask

  task automatic test_boundary;
    int n;
    n = 0;
    data_req = 1'b1; data_we = 1'b0; data_addr = 64'h8000_0200;
    ack_delay = 7; mem_rdata_val = 64'h1234_5678;
    samp;
    tick;
    data_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      samp;
      if (!mem_req) break;
      n++;
      tick;
    end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL boundary_len got %0d mem_req cycles required 8", n); end
    checks++;
    if (data_rvalid !== 1'b1 || err !== 1'b0 || data_rdata !== 64'h1234_5678) begin
      errors++; $display("FAIL boundary_resp rvalid=%0b err=%0b rdata=%h required 1 0 12345678", data_rvalid, err, data_rdata);
    end
    tick;
    samp;
    checks++;
    if (data_rvalid !== 1'b0 || data_rdata !== 64'h1234_5678) begin
      errors++; $display("FAIL boundary_hold rvalid=%0b rdata=%h required 0 12345678", data_rvalid, data_rdata);
    end
    tick;
    inst_req = 1'b1; inst_addr = 64'h8000_0300; ack_delay = 0; mem_rdata_val = 64'hAAAA;
    samp;
    tick;
    inst_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      samp;
      if (inst_rvalid) break;
      tick;
    end
    checks++;
    if (inst_rvalid !== 1'b1 || inst_rdata !== 64'hAAAA || data_rdata !== 64'h1234_5678) begin
      errors++; $display("FAIL boundary_other irv=%0b irdata=%h drdata=%h required 1 aaaa 12345678", inst_rvalid, inst_rdata, data_rdata);
    end
    tick;
    wait_idle;
  endtask

  task automatic test_reset_mid;
    data_req = 1'b1; data_we = 1'b0; data_addr = 64'h8000_0400; ack_delay = -1;
    samp;
    tick;
    data_req = 1'b0;
    tick;
    tick;
    samp;
    checks++;
    if (busy !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre busy=%0b req=%0b required 1 1", busy, mem_req); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, mem_req, data_rvalid, err, data_gnt, inst_gnt} !== 6'b0 || mem_addr !== 64'h0) begin
      errors++; $display("FAIL rstmid_async ctrl=%b addr=%h required 000000 0", {busy, mem_req, data_rvalid, err, data_gnt, inst_gnt}, mem_addr);
    end
    tick;
    samp;
    checks++;
    if (data_rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_held rvalid=%0b busy=%0b required 0 0", data_rvalid, busy); end
    tick;
    rst = 1'b0;
    inst_req = 1'b1; inst_addr = 64'h8000_0000; ack_delay = 0; mem_rdata_val = 64'h77;
    samp;
    checks++;
    if (inst_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got %0b required 1", inst_gnt); end
    tick;
    inst_req = 1'b0;
    samp;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0000) begin errors++; $display("FAIL rstmid_mem req=%0b addr=%h required 1 80000000", mem_req, mem_addr); end
    tick;
    samp;
    checks++;
    if (inst_rvalid !== 1'b1 || inst_rdata !== 64'h77) begin errors++; $display("FAIL rstmid_resp rvalid=%0b rdata=%h required 1 77", inst_rvalid, inst_rdata); end
    tick;
    wait_idle;
  endtask

  initial begin
    test_reset;
    test_single_load;
    test_store;
    test_conflict;
    test_timeout;
    test_boundary;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
